// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: operation modes and
// the control FSM state encoding.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder. Subtraction is handled by the caller (inverted operand,
// carry-in of 1), so the cell is reusable by any adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell processes one
// bit per clock, LSB first, behind a start/done handshake.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic               carry;
  logic               msb_cin;
  logic [CNT_W-1:0]   cnt;
  logic               cell_s;
  logic               cell_co;

  fa_cell u_fa_cell (
    .x  (sh_a[0]),
    .y  (sh_b[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // Status flags decode directly from the registered state, so they are glitch-free.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert B here, inject the +1 as carry-in.
            sh_a  <= a;
            sh_b  <= (mode == MODE_SUB) ? ~b : b;
            carry <= mode;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result <= {cell_s, result[WIDTH-1:1]};
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          carry  <= cell_co;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            msb_cin <= carry;
            cout    <= cell_co;
            ovf     <= carry ^ cell_co;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH 8, 2 and 32, against an
// arithmetic reference model with directed and $urandom stimulus.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  a8, b8, res8;
  logic [1:0]  a2, b2, res2;
  logic [31:0] a32, b32, res32;
  logic        busy8, done8, cout8, ovf8;
  logic        busy2, done2, cout2, ovf2;
  logic        busy32, done32, cout32, ovf32;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2)
  );

  serial_addsub #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .cout(cout32), .ovf(ovf32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modulo-2^w arithmetic; returns {cout, ovf, result}.
  function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                        input logic [63:0] bv, input logic m);
    logic [64:0] mask, ax, bx, full, res;
    logic co, ov, sa, sb;
    mask = (65'd1 << w) - 65'd1;
    ax   = {1'b0, av} & mask;
    bx   = {1'b0, bv} & mask;
    full = m ? (ax + ((~bx) & mask) + 65'd1) : (ax + bx);
    res  = full & mask;
    co   = full[w];
    sa   = ax[w-1];
    sb   = m ? ~bx[w-1] : bx[w-1];
    ov   = (sa == sb) && (res[w-1] != sa);
    return {co, ov, res[63:0]};
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      2:       return done2;
      32:      return done32;
      default: return done8;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      2:       return busy2;
      32:      return busy32;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [65:0] outs_of(input int w);
    case (w)
      2:       return {cout2, ovf2, 62'd0, res2};
      32:      return {cout32, ovf32, 32'd0, res32};
      default: return {cout8, ovf8, 56'd0, res8};
    endcase
  endfunction

  // One operation on the width-w instance; optionally reset it mid-run.
  task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                        input logic m, input bit do_reset, input string tag);
    int lat;
    int guard;
    bit dropped;
    int rb;
    logic [65:0] exp, got;
    @(negedge clk);
    guard = 0;
    while (busy_of(w) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    case (w)
      2:       begin a2  = av[1:0];  b2  = bv[1:0];  end
      32:      begin a32 = av[31:0]; b32 = bv[31:0]; end
      default: begin a8  = av[7:0];  b8  = bv[7:0];  end
    endcase
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (do_reset) begin
      rb = (w > 3) ? 3 : 1;
      repeat (rb) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check({tag, "_rst_busy"}, 64'(busy_of(w)), 64'd0);
      check({tag, "_rst_done"}, 64'(done_of(w)), 64'd0);
      check({tag, "_rst_outs"}, outs_of(w), 66'd0);
      return;
    end
    lat = 1;
    dropped = 1'b0;
    while (!done_of(w) && lat < 200) begin
      if (!busy_of(w)) dropped = 1'b1;
      @(negedge clk);
      lat++;
    end
    // Counted from the start edge through the edge that raises done.
    check({tag, "_latency"}, 64'(lat), 64'(w + 1));
    check({tag, "_busy_held"}, 64'(dropped), 64'd0);
    exp = model(w, av, bv, m);
    got = outs_of(w);
    check({tag, "_result"}, got[63:0], exp[63:0]);
    check({tag, "_cout"}, 64'(got[65]), 64'(exp[65]));
    check({tag, "_ovf"}, 64'(got[64]), 64'(exp[64]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done_of(w)), 64'd0);
    got = outs_of(w);
    check({tag, "_hold"}, got[63:0], exp[63:0]);
  endtask

  task automatic handshake(input int n_edges);
    logic [7:0] pa [];
    logic [7:0] pb [];
    logic       pm [];
    logic [65:0] exp;
    int ph;
    pa = new[n_edges];
    pb = new[n_edges];
    pm = new[n_edges];
    @(negedge clk);
    for (int e = 0; e < n_edges; e++) begin
      pa[e] = 8'($urandom);
      pb[e] = 8'($urandom);
      pm[e] = 1'($urandom);
      a8 = pa[e];
      b8 = pb[e];
      mode = pm[e];
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Accepts happen at edges 0, 9, 18, ...; done is visible after edge 8, 17, ...
      ph = e % 9;
      check("hs_done", 64'(done8), 64'(ph == 8));
      check("hs_busy", 64'(busy8), 64'(ph != 8));
      if (ph == 8) begin
        exp = model(8, 64'(pa[e-8]), 64'(pb[e-8]), pm[e-8]);
        check("hs_result", 64'(res8), exp[63:0]);
        check("hs_cout", 64'(cout8), 64'(exp[65]));
        check("hs_ovf", 64'(ovf8), 64'(exp[64]));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_outs8", outs_of(8), 66'd0);
    check("reset_outs2", outs_of(2), 66'd0);
    check("reset_outs32", outs_of(32), 66'd0);
    rst_n = 1'b1;

    run_op(8, 64'd200,  64'd100, 1'b0, 1'b0, "add_200_100");
    run_op(8, 64'd100,  64'd100, 1'b0, 1'b0, "add_ovf");
    run_op(8, 64'd5,    64'd7,   1'b1, 1'b0, "sub_borrow");
    run_op(8, 64'd7,    64'd5,   1'b1, 1'b0, "sub_7_5");
    run_op(8, 64'h80,   64'h01,  1'b1, 1'b0, "sub_ovf");
    run_op(8, 64'h00,   64'h00,  1'b1, 1'b0, "sub_zero");
    run_op(8, 64'hFF,   64'hFF,  1'b0, 1'b0, "add_ff_ff");

    for (int i = 0; i < 16; i++)
      run_op(8, 64'($urandom), 64'($urandom), 1'($urandom), 1'b0, "rand8");

    handshake(36);

    run_op(8, 64'd200, 64'd100, 1'b0, 1'b0, "pre_reset8");
    run_op(8, 64'hA5,  64'h3C,  1'b0, 1'b1, "mid8");
    run_op(8, 64'hA5,  64'h3C,  1'b1, 1'b0, "post_reset8");

    run_op(2, 64'd3, 64'd1, 1'b0, 1'b1, "mid2");
    run_op(2, 64'd3, 64'd1, 1'b0, 1'b0, "w2_3p1");
    run_op(2, 64'd1, 64'd2, 1'b1, 1'b0, "w2_1m2");

    run_op(32, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, "mid32");
    run_op(32, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, "w32_max_p1");
    for (int i = 0; i < 4; i++)
      run_op(32, 64'($urandom), 64'($urandom), 1'($urandom), 1'b0, "rand32");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
